mux_rr_sel_arbiter: RTL and testbench

Round-robin arbiter that sits directly upstream of the 4:1 mux tree and drives its 2-bit SEL.
- Four requesters contend for the shared mux path.
- The block grants one requester at a time and holds SEL stable for a burst of beats.
- Each beat completes on a VALID/READY handshake with the downstream consumer of the mux output.
- SEL changes only between grants, never mid-burst.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_rr_sel_arbiter_if.sv | 28 ++
 rtl/mux_rr_sel_arbiter_rr_pick4.sv | 28 ++
 rtl/mux_rr_sel_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_sel_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_pkg
// Brief    : Shared constants and FSM state encoding for the mux select arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
package mux_pkg;

  localparam int c_SEL_W             = 2;
  localparam int c_NUM_REQ           = 4;
  localparam int c_CNT_W             = 4;
  localparam int c_BURST_LEN_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_sel_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_rr_sel_arbiter_if
// Brief    : Request/handshake/select bundle; lock present with MUX_RR_SEL_LOCK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
interface mux_rr_sel_arbiter_if;
  import mux_pkg::*;

  logic [c_NUM_REQ-1:0] req;
  logic                 ready;
  logic [c_SEL_W-1:0]   sel;
  logic [c_NUM_REQ-1:0] gnt;
  logic                 valid;
  logic [c_CNT_W-1:0]   beat_cnt;

`ifdef MUX_RR_SEL_LOCK_EN
  logic                 lock;

  modport master (input req, ready, lock, output sel, gnt, valid, beat_cnt);
  modport slave  (output req, ready, lock, input sel, gnt, valid, beat_cnt);
`else
  modport master (input req, ready, output sel, gnt, valid, beat_cnt);
  modport slave  (output req, ready, input sel, gnt, valid, beat_cnt);
`endif

endinterface
`default_nettype wire

// File: rtl/mux_rr_sel_arbiter_rr_pick4.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_pick4
// Brief    : Combinational 4-way round-robin pick starting the search at ptr.
// Revision : 1.0
//------------------------------------------------------------------------------
module rr_pick4
  import mux_pkg::*;
(
  input  logic [c_NUM_REQ-1:0] req,
  input  logic [c_SEL_W-1:0]   ptr,
  output logic [c_SEL_W-1:0]   index,
  output logic                 any
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    index = ptr;
    any   = |req;
    for (int i = c_NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + c_SEL_W'(i)]) begin
        index = ptr + c_SEL_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_sel_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_rr_sel_arbiter
// Brief    : Round-robin burst arbiter driving the 4:1 mux SEL.
//            Optional burst lock enabled by macro MUX_RR_SEL_LOCK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
module mux_rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int BURST_LEN = c_BURST_LEN_DEFAULT
)(
  input  logic                 clk,
  input  logic                 rst_n,
  mux_rr_sel_arbiter_if.master bus
);

  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;

  state_t               r_state, w_state_nxt;
  logic [c_SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [c_SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_SEL_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic                 w_lock;
  logic                 w_last;

`ifdef MUX_RR_SEL_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .index (w_pick_idx),
    .any   (w_pick_any)
  );

  // Evaluated only on a completing beat, so an offered beat is never withdrawn.
  assign w_last = !bus.req[r_sel] || (!w_lock && (r_cnt == c_LAST_BEAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (bus.ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = r_sel + c_SEL_W'(1);
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + c_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.sel      = r_sel;
  assign bus.valid    = (r_state == ST_GRANT);
  assign bus.gnt      = (r_state == ST_GRANT) ? (c_NUM_REQ'(1) << r_sel) : '0;
  assign bus.beat_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sel_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mux_rr_sel_arbiter
// Brief    : Directed bench with a burst-level reference model (BURST_LEN 4 and 1).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_mux_rr_sel_arbiter;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   lock_drv = 1'b0;
  bit   model_on = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  mux_rr_sel_arbiter_if if_a ();
  mux_rr_sel_arbiter_if if_b ();

  assign if_b.req   = if_a.req;
  assign if_b.ready = if_a.ready;
`ifdef MUX_RR_SEL_LOCK_EN
  assign if_a.lock  = lock_drv;
  assign if_b.lock  = lock_drv;
`endif

  mux_rr_sel_arbiter #(.BURST_LEN(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
  mux_rr_sel_arbiter #(.BURST_LEN(1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(if_b.master));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst-level model of the BURST_LEN=4 instance: who owns the path, beats done.
  bit m_busy;
  int m_owner, m_ptr, m_beats;

  always @(posedge clk) begin : p_model
    int c;
    int done;
    bit found;
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_beats <= 0;
    end else if (!m_busy) begin
      if (if_a.req != 4'b0000) begin
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && if_a.req[(m_ptr + k) % 4]) begin
            c     = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_owner <= c;
        m_busy  <= 1'b1;
        m_beats <= 0;
      end
    end else if (if_a.ready) begin
      done = m_beats + 1;
      if (!if_a.req[m_owner] || (!lock_drv && done == 4)) begin
        m_busy  <= 1'b0;
        m_ptr   <= (m_owner + 1) % 4;
        m_beats <= 0;
      end else begin
        m_beats <= (done > 15) ? 15 : done;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_valid", 32'(if_a.valid), 32'(m_busy));
      chk("model_gnt", 32'(if_a.gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
      chk("model_sel", 32'(if_a.sel), 32'(m_owner));
      chk("model_cnt", 32'(if_a.beat_cnt), 32'(m_beats));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_a(input string nm, input logic v, input logic [1:0] s,
                       input logic [3:0] g, input logic [3:0] c);
    chk({nm, "_valid"}, 32'(if_a.valid), 32'(v));
    chk({nm, "_sel"}, 32'(if_a.sel), 32'(s));
    chk({nm, "_gnt"}, 32'(if_a.gnt), 32'(g));
    chk({nm, "_cnt"}, 32'(if_a.beat_cnt), 32'(c));
  endtask

  initial begin
    int ph;
    if_a.req   = 4'b0000;
    if_a.ready = 1'b0;
    rst_n      = 1'b0;
    step(2);
    rst_n    = 1'b1;
    model_on = 1'b1;
    chk_a("reset", 1'b0, 2'd0, 4'b0000, 4'd0);

    // Single requester 2, full burst of four beats.
    if_a.req   = 4'b0100;
    if_a.ready = 1'b1;
    step();
    chk_a("t1_first", 1'b1, 2'd2, 4'b0100, 4'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_a("t1_beat", 1'b1, 2'd2, 4'b0100, 4'(i));
    end
    step();
    chk_a("t1_end", 1'b0, 2'd2, 4'b0000, 4'd0);
    chk("t1_ptr", 32'(m_ptr), 32'd3);
    if_a.req = 4'b0000;

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // All requesting: fair rotation, one idle bubble between grants.
    if_a.req = 4'b1111;
    for (int t = 1; t <= 25; t++) begin
      step();
      ph = (t - 1) % 5;
      if (ph < 4)
        chk_a("t2_grant", 1'b1, 2'(((t - 1) / 5) % 4), 4'b0001 << (((t - 1) / 5) % 4), 4'(ph));
      else
        chk_a("t2_bubble", 1'b0, 2'(((t - 1) / 5) % 4), 4'b0000, 4'd0);
      chk("t2_b1_valid", 32'(if_b.valid), 32'(((t - 1) % 2) == 0));
      chk("t2_b1_sel", 32'(if_b.sel), 32'(((t - 1) / 2) % 4));
      chk("t2_b1_cnt", 32'(if_b.beat_cnt), 32'd0);
    end
    if_a.req = 4'b0000;
    chk("t2_ptr", 32'(m_ptr), 32'd1);

    // Owner 1 drops its request after the second beat.
    if_a.req = 4'b1110;
    step();
    chk_a("t3_first", 1'b1, 2'd1, 4'b0010, 4'd0);
    step();
    chk_a("t3_beat1", 1'b1, 2'd1, 4'b0010, 4'd1);
    if_a.req = 4'b1100;
    step();
    chk_a("t3_end", 1'b0, 2'd1, 4'b0000, 4'd0);
    chk("t3_ptr", 32'(m_ptr), 32'd2);
    step();
    chk_a("t3_next", 1'b1, 2'd2, 4'b0100, 4'd0);
    if_a.req = 4'b0000;
    step();
    chk("t3_next_end", 32'(if_a.valid), 32'd0);

    // Reset in the middle of a burst, then pointer must restart at 0.
    if_a.req = 4'b0100;
    step(3);
    chk_a("t5_pre", 1'b1, 2'd2, 4'b0100, 4'd2);
    rst_n = 1'b0;
    step();
    chk_a("t5_reset", 1'b0, 2'd0, 4'b0000, 4'd0);
    rst_n    = 1'b1;
    if_a.req = 4'b1010;
    step();
    chk_a("t5_regrant", 1'b1, 2'd1, 4'b0010, 4'd0);
    if_a.req = 4'b0000;
    step();
    chk("t5_end", 32'(if_a.valid), 32'd0);

    // Stall with owner's request gone: beat stays offered until READY.
    if_a.req = 4'b1000;
    step(2);
    chk_a("t4_pre", 1'b1, 2'd3, 4'b1000, 4'd1);
    if_a.ready = 1'b0;
    if_a.req   = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("t4_stall", 1'b1, 2'd3, 4'b1000, 4'd1);
    end
    if_a.ready = 1'b1;
    step();
    chk_a("t4_end", 1'b0, 2'd3, 4'b0000, 4'd0);
    chk("t4_ptr", 32'(m_ptr), 32'd0);

`ifdef MUX_RR_SEL_LOCK_EN
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    lock_drv = 1'b1;
    if_a.req = 4'b0001;
    step();
    chk_a("t6_first", 1'b1, 2'd0, 4'b0001, 4'd0);
    for (int k = 1; k < 20; k++) begin
      step();
      chk_a("t6_lock", 1'b1, 2'd0, 4'b0001, 4'((k > 15) ? 15 : k));
    end
    lock_drv = 1'b0;
    if_a.req = 4'b0000;
    step();
    chk_a("t6_end", 1'b0, 2'd0, 4'b0000, 4'd0);
    chk("t6_ptr", 32'(m_ptr), 32'd1);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
